// File: rtl/store_commit_arbiter.sv
// store_commit_arbiter
//
// Purpose:
//   Holds stores released by retire in a small circular buffer. Drains them
//   in retire order to the single data-memory port, and shares that port with
//   load requests from the LSQ issue path. A load that hits the same
//   doubleword as any buffered store is held back until that store has gone
//   out. Loads may overtake waiting stores for at most STARVE_LIMIT
//   consecutive issues. drain_req (fence/halt) flushes the buffer and blocks
//   new loads.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   reset      in   asynchronous, active-low; clears all state while 0
//   st_valid   in   retired store this cycle
//   st_addr    in   store byte address
//   st_data    in   store data, LSB-aligned
//   st_size    in   store bytes (1, 2, 4, 8)
//   full       out  buffer holds DEPTH entries (retire stall source)
//   count      out  occupied entries
//   ld_req     in   load wants the port; held with ld_addr/ld_size until ld_grant
//   ld_addr    in   load address
//   ld_size    in   load bytes
//   ld_grant   out  one-cycle pulse when the load's transaction completes
//   mem_req    out  transaction valid
//   mem_we     out  1 = store, 0 = load
//   mem_addr   out  transaction address
//   mem_wdata  out  store data, 0 for loads
//   mem_size   out  transaction bytes
//   mem_ack    in   memory accepted/completed the current transaction
//   drain_req  in   flush request: empty the buffer, issue no new loads
//   drained    out  drain_req with buffer empty and FSM idle
module store_commit_arbiter #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [3:0]                 st_size,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       ld_req,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [3:0]                 ld_size,
    output logic                       ld_grant,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [3:0]                 mem_size,
    input  logic                       mem_ack,
    input  logic                       drain_req,
    output logic                       drained
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_BUSY = 2'd1,
        LD_BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STV_W-1:0]   starve_q, starve_d;

    // Buffer payload. Validity comes from head/count, so the payload itself
    // needs no reset.
    logic [ADDR_W-1:0]  buf_addr_q [DEPTH];
    logic [DATA_W-1:0]  buf_data_q [DEPTH];
    logic [3:0]         buf_size_q [DEPTH];

    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [3:0]         mem_size_q;

    logic               push;
    logic               pop;
    logic               load_st;
    logic               load_ld;
    logic               alias_hit;
    logic               has_entries;
    logic               starved;
    logic [PTR_W-1:0]   offs;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign has_entries = (count_q != '0);
    assign starved     = (starve_q == STV_W'(STARVE_LIMIT));
    // A store arriving while full is dropped; retire is stalled by full.
    assign push        = st_valid && !full;

    // Doubleword alias check against every occupied slot. An entry is
    // occupied when its distance from head (mod DEPTH) is below count.
    always_comb begin
        alias_hit = 1'b0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - head_q;
            if ((CNT_W'(offs) < count_q) &&
                (buf_addr_q[i][ADDR_W-1:3] == ld_addr[ADDR_W-1:3])) begin
                alias_hit = 1'b1;
            end
        end
    end

    // Next-state and transaction selection.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        load_st  = 1'b0;
        load_ld  = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (has_entries && (full || drain_req || starved)) begin
                    state_d  = ST_BUSY;
                    starve_d = '0;
                    load_st  = 1'b1;
                end else if (ld_req && !drain_req && !alias_hit) begin
                    state_d = LD_BUSY;
                    load_ld = 1'b1;
                    // Only loads that bypass waiting stores count toward starvation.
                    if (has_entries) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end else if (has_entries) begin
                    state_d  = ST_BUSY;
                    starve_d = '0;
                    load_st  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                end
            end
            LD_BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer and occupancy update.
    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[tail_q] <= st_addr;
            buf_data_q[tail_q] <= st_data;
            buf_size_q[tail_q] <= st_size;
        end
    end

    // Transaction fields are captured when the FSM leaves IDLE and held
    // until the ack; they return to zero once the transaction ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
        end else if (load_st) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= buf_addr_q[head_q];
            mem_wdata_q <= buf_data_q[head_q];
            mem_size_q  <= buf_size_q[head_q];
        end else if (load_ld) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ld_addr;
            mem_wdata_q <= '0;
            mem_size_q  <= ld_size;
        end else if ((state_q != IDLE) && mem_ack) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
        end
    end

    assign count     = count_q;
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign ld_grant  = (state_q == LD_BUSY) && mem_ack;
    // Gated by reset so every output reads 0 while reset is held.
    assign drained   = reset && drain_req && !has_entries && (state_q == IDLE);

endmodule
